gonso_wb_pwm_bank: RTL and testbench
====================================

// Module: gonso_wb_pwm_bank
// PURPOSE
//  Wishbone-mapped bank of NCH edge-aligned PWM channels driving motor/LED pads (io_out[35:32] and up).
//  Successor to the single fixed-width gonso motor driver: channel count, counter width and base
//  address are parametrised. Adds shadowed (glitch-free) duty/period updates and a maskable wrap IRQ.
//  Sits directly on the Caravel user Wishbone slave port, next to the user_proj wrapper.
// PARAMETERS
//  NCH        4             number of PWM channels, legal 1..12
//  PSIZE      20            counter/period/duty width in bits, legal 2..32
//  BASE_ADDR  32'h3000_0000 block base; decode on wbs_adr_i[31:8] == BASE_ADDR[31:8]
// PORTS
//  clk        in   1      system clock (wb_clk_i)
//  rst_n      in   1      asynchronous active-low reset
//  wbs_cyc_i  in   1      Wishbone cycle
//  wbs_stb_i  in   1      Wishbone strobe
//  wbs_we_i   in   1      write enable
//  wbs_sel_i  in   4      byte lane selects (writes only)
//  wbs_adr_i  in   32     byte address
//  wbs_dat_i  in   32     write data
//  wbs_dat_o  out  32     read data, valid while wbs_ack_o=1
//  wbs_ack_o  out  1      single-cycle acknowledge
//  pwm_o      out  NCH    PWM outputs, bit i = channel i
//  irq        out  1      level interrupt
// BEHAVIOUR
//  Reset: all registers 0; wbs_ack_o=0, wbs_dat_o=0, pwm_o=0, irq=0, counter=0.
//  Register map (offset = wbs_adr_i[7:0], word aligned):
//   0x00 CTRL    [0] global EN, [8+i] channel i enable (RW)
//   0x04 STATUS  [0] WRAP flag, write-1-to-clear (R/W1C)
//   0x08 IRQEN   [0] WRAP irq enable (RW)
//   0x0C PERIOD  [PSIZE-1:0] (RW, live copy)
//   0x10+4*i DUTY[i] [PSIZE-1:0] (RW, live copy); unmapped offsets read 0, writes ignored.
//  Bus: access = cyc & stb & decode hit & !wbs_ack_o. Ack asserted the cycle after access, for
//   exactly 1 cycle; back-to-back strobes ack every other cycle. Writes commit on the access cycle,
//   per byte lane in wbs_sel_i. Bits above PSIZE / unused read 0. Non-hit strobe: no ack.
//  Counter: when EN=1 and PERIOD_act!=0: cnt increments each cycle; at cnt==PERIOD_act next cnt=0
//   (wrap). Wrap cycle: PERIOD_act<=PERIOD, DUTY_act[i]<=DUTY[i], STATUS.WRAP<=1.
//  Output (registered, 1-cycle latency from cnt): pwm_o[i] = EN & CTRL[8+i] & (cnt < DUTY_act[i]).
//   DUTY=0 -> constant 0; DUTY>PERIOD -> constant 1; period length = PERIOD_act+1 cycles.
//  EN 1->0: cnt forced 0, pwm_o 0 next cycle. While EN=0: shadows track live regs every cycle,
//   so first period after EN 0->1 uses current PERIOD/DUTY values.
//  PERIOD_act==0 with EN=1: cnt held 0, pwm_o 0, no wrap events; escape via next EN toggle
//   (shadows reload while EN=0).
//  Live-register writes mid-period never change pwm_o until the next wrap.
//  W1C same cycle as a wrap: set wins, WRAP stays 1.
//  irq registered: irq <= STATUS.WRAP & IRQEN[0].
//  rst_n assert mid-transfer: all state cleared immediately, pending ack dropped.
// TESTING
//  1 Reset: rst_n low mid-run, no clk -> pwm_o=0, irq=0, wbs_ack_o=0 asynchronously.
//  2 PERIOD=9, DUTY0=3, CTRL=0x101 -> pwm_o[0] high 3 of every 10 cycles; ack 1 cycle per access.
//  3 Running DUTY0=3, write DUTY0=7 mid-period -> duty changes exactly at next wrap, no runt pulse.
//  4 DUTY1=0, DUTY2=20 (PERIOD=9), CTRL=0x701 -> pwm_o[1] always 0, pwm_o[2] always 1.
//  5 IRQEN=1 -> irq rises 1 cycle after WRAP; W1C 0x04=1 -> irq falls; W1C on wrap cycle -> stays 1.
//  6 Read 0x40 and any write with wbs_sel_i=0 -> reads 0, registers unchanged, ack still given.

Source files
------------

// File: rtl/gonso_wb_pwm_bank.sv
// Wishbone-mapped bank of edge-aligned PWM channels with shadowed period/duty registers
// and a maskable wrap interrupt; registers reload from the live copies only at a wrap.
module gonso_wb_pwm_bank #(
  parameter int          NCH       = 4,
  parameter int          PSIZE     = 20,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic [31:0]      wbs_dat_o,
  output logic             wbs_ack_o,
  output logic [NCH-1:0]   pwm_o,
  output logic             irq
);

  logic             hit;
  logic             access;
  logic             wr;
  logic [5:0]       word;
  logic [31:0]      rdata;

  logic             en;
  logic [NCH-1:0]   ch_en;
  logic             wrap_flag;
  logic             irq_en;
  logic [PSIZE-1:0] period;
  logic [PSIZE-1:0] duty [NCH];

  logic [PSIZE-1:0] period_act;
  logic [PSIZE-1:0] duty_act [NCH];
  logic [PSIZE-1:0] cnt;
  logic             run;
  logic             wrap;

  logic             unused_bits;

  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i};

  assign hit    = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign access = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o;
  assign wr     = access & wbs_we_i;
  assign word   = wbs_adr_i[7:2];

  assign run  = en & (period_act != '0);
  assign wrap = run & (cnt == period_act);

  // Byte-lane merge of a bus write into a PSIZE-wide register.
  function automatic logic [PSIZE-1:0] lane_merge(input logic [PSIZE-1:0] old,
                                                  input logic [31:0]      data,
                                                  input logic [3:0]       sel);
    logic [PSIZE-1:0] r;
    for (int b = 0; b < PSIZE; b++) r[b] = sel[b/8] ? data[b] : old[b];
    return r;
  endfunction

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    rdata = '0;
    case (word)
      6'd0: begin
        rdata[0]         = en;
        rdata[8 +: NCH]  = ch_en;
      end
      6'd1: rdata[0] = wrap_flag;
      6'd2: rdata[0] = irq_en;
      6'd3: rdata[PSIZE-1:0] = period;
      default: begin
        for (int i = 0; i < NCH; i++)
          if (word == 6'(i + 4)) rdata[PSIZE-1:0] = duty[i];
      end
    endcase
  end

  // Bus side: live registers, status flag, ack and read data.
  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      en        <= 1'b0;
      ch_en     <= '0;
      wrap_flag <= 1'b0;
      irq_en    <= 1'b0;
      irq       <= 1'b0;
      period    <= '0;
      // NOTE: the duty arrays are a handful of flops, not RAM, so they take the reset like any register.
      for (int i = 0; i < NCH; i++) duty[i] <= '0;
    end else begin
      wbs_ack_o <= access;
      wbs_dat_o <= (access & ~wbs_we_i) ? rdata : '0;

      if (wr && word == 6'd0) begin
        if (wbs_sel_i[0]) en <= wbs_dat_i[0];
        for (int i = 0; i < NCH; i++)
          if (wbs_sel_i[(8 + i) / 8]) ch_en[i] <= wbs_dat_i[8 + i];
      end
      if (wr && word == 6'd2 && wbs_sel_i[0]) irq_en <= wbs_dat_i[0];
      if (wr && word == 6'd3) period <= lane_merge(period, wbs_dat_i, wbs_sel_i);
      for (int i = 0; i < NCH; i++)
        if (wr && word == 6'(i + 4)) duty[i] <= lane_merge(duty[i], wbs_dat_i, wbs_sel_i);

      // A wrap on the same edge as a W1C keeps the flag set.
      if (wrap)
        wrap_flag <= 1'b1;
      else if (wr && word == 6'd1 && wbs_sel_i[0] && wbs_dat_i[0])
        wrap_flag <= 1'b0;

      irq <= wrap_flag & irq_en;
    end
  end

  // PWM engine: counter, shadow registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      period_act <= '0;
      pwm_o      <= '0;
      for (int i = 0; i < NCH; i++) duty_act[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++)
        pwm_o[i] <= run & ch_en[i] & (cnt < duty_act[i]);

      // Shadows follow the live registers while disabled, otherwise only at a wrap.
      if (!en || wrap) begin
        cnt        <= '0;
        period_act <= period;
        for (int i = 0; i < NCH; i++) duty_act[i] <= duty[i];
      end else if (run) begin
        cnt <= cnt + PSIZE'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gonso_wb_pwm_bank.sv
// Randomised scoreboard bench for gonso_wb_pwm_bank: a cycle-level reference model
// predicts ack/pwm/irq and queues expected read data; a negedge monitor compares.
module tb_gonso_wb_pwm_bank;

  localparam int          NCH       = 4;
  localparam int          PSIZE     = 20;
  localparam logic [31:0] BASE      = 32'h3000_0000;
  localparam logic [31:0] PMASK     = 32'h000F_FFFF;
  localparam logic [31:0] CTRL_MASK = 32'h0000_0F01;

  logic           clk;
  logic           rst_n;
  logic           wbs_cyc_i;
  logic           wbs_stb_i;
  logic           wbs_we_i;
  logic [3:0]     wbs_sel_i;
  logic [31:0]    wbs_adr_i;
  logic [31:0]    wbs_dat_i;
  logic [31:0]    wbs_dat_o;
  logic           wbs_ack_o;
  logic [NCH-1:0] pwm_o;
  logic           irq;

  gonso_wb_pwm_bank #(.NCH(NCH), .PSIZE(PSIZE), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_dat_o (wbs_dat_o),
    .wbs_ack_o (wbs_ack_o),
    .pwm_o     (pwm_o),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        rd;
    logic [31:0] data;
  } exp_t;

  exp_t           exp_q[$];
  logic [31:0]    m_ctrl, m_irqen, m_period, m_act_period, m_phase;
  logic [31:0]    m_duty [NCH];
  logic [31:0]    m_act_duty [NCH];
  logic           m_flag, m_ack, m_irq;
  logic [NCH-1:0] m_pwm;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [3:0] sel);
    logic [31:0] m;
    m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return (old & ~m) | (dat & m);
  endfunction

  function automatic logic [31:0] m_read(input int w);
    if (w == 0) return m_ctrl;
    if (w == 1) return {31'd0, m_flag};
    if (w == 2) return m_irqen;
    if (w == 3) return m_period;
    if (w >= 4 && w < 4 + NCH) return m_duty[w - 4];
    return 32'd0;
  endfunction

  function automatic bit m_running();
    return m_ctrl[0] && (m_act_period != 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ctrl = 0; m_irqen = 0; m_period = 0; m_act_period = 0; m_phase = 0;
      m_flag = 0; m_ack = 0; m_irq = 0; m_pwm = '0;
      for (int i = 0; i < NCH; i++) begin m_duty[i] = 0; m_act_duty[i] = 0; end
      exp_q.delete();
    end else begin
      automatic bit acc  = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:8] == BASE[31:8]) && !m_ack;
      automatic int w    = int'(wbs_adr_i[7:2]);
      automatic bit run  = m_running();
      automatic bit wrp  = run && (m_phase == m_act_period);
      automatic bit w1c  = acc && wbs_we_i && w == 1 && wbs_sel_i[0] && wbs_dat_i[0];

      for (int i = 0; i < NCH; i++) m_pwm[i] = run && m_ctrl[8 + i] && (m_phase < m_act_duty[i]);
      m_irq = m_flag && m_irqen[0];

      if (!m_ctrl[0] || wrp) begin
        m_phase = 0; m_act_period = m_period; m_act_duty = m_duty;
      end else if (run) m_phase = m_phase + 1;
      else m_phase = 0;

      if (acc) exp_q.push_back('{rd: !wbs_we_i, data: m_read(w)});
      m_ack = acc;

      if (wrp) m_flag = 1'b1;
      else if (w1c) m_flag = 1'b0;

      if (acc && wbs_we_i) begin
        if (w == 0) m_ctrl = merge(m_ctrl, wbs_dat_i, wbs_sel_i) & CTRL_MASK;
        if (w == 2) m_irqen = merge(m_irqen, wbs_dat_i, wbs_sel_i) & 32'd1;
        if (w == 3) m_period = merge(m_period, wbs_dat_i, wbs_sel_i) & PMASK;
        if (w >= 4 && w < 4 + NCH) m_duty[w - 4] = merge(m_duty[w - 4], wbs_dat_i, wbs_sel_i) & PMASK;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("ack", wbs_ack_o, m_ack);
      check("pwm", pwm_o, m_pwm);
      check("irq", irq, m_irq);
      if (wbs_ack_o) begin
        check("ack_has_expected_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          automatic exp_t e = exp_q.pop_front();
          if (e.rd) check("read_data", wbs_dat_o, e.data);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input int hold);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    repeat (hold) @(posedge clk);
    #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] dat);
    bus(1'b1, BASE + {24'd0, off}, dat, 4'hF, 1);
  endtask

  task automatic rd(input logic [7:0] off);
    bus(1'b0, BASE + {24'd0, off}, 32'd0, 4'hF, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until the model says the next edge is a wrap, or its phase equals ph.
  task automatic wait_phase(input bit at_wrap, input logic [31:0] ph);
    int n = 0;
    while (n < 200 && !(m_running() && (at_wrap ? (m_phase == m_act_period) : (m_phase == ph)))) begin
      @(posedge clk); #1;
      n++;
    end
    check("phase_wait_in_budget", n < 200, 1);
  endtask

  task automatic count_high(input int ch, input int cycles, output int hi);
    hi = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (pwm_o[ch]) hi++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int hi;
    rst_n = 1'b0; wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
    #3;
    check("reset_pwm", pwm_o, 0);
    check("reset_irq", irq, 0);
    check("reset_ack", wbs_ack_o, 0);
    check("reset_dat", wbs_dat_o, 0);
    #19 rst_n = 1'b1;
    idle(2);
    rd(8'h00); rd(8'h04); rd(8'h0C);

    // Basic PWM: 3 high of every 10 cycles.
    wr(8'h0C, 9); wr(8'h10, 3); wr(8'h00, 32'h101);
    idle(5);
    count_high(0, 30, hi);
    check("duty3_high_count", hi, 9);

    // Mid-period duty change lands at the next wrap.
    wait_phase(0, 5);
    wr(8'h10, 7);
    idle(25);
    count_high(0, 30, hi);
    check("duty7_high_count", hi, 21);

    // Duty boundaries: 0 -> always low, above period -> always high.
    wr(8'h14, 0); wr(8'h18, 20); wr(8'h00, 32'h701);
    idle(15);
    count_high(1, 20, hi);
    check("duty0_never_high", hi, 0);
    count_high(2, 20, hi);
    check("duty_gt_period_always_high", hi, 20);

    // Unmapped read, sel=0 write ignored, back-to-back strobes.
    rd(8'h40);
    bus(1'b1, BASE + 32'h0C, 32'h55, 4'h0, 1);
    rd(8'h0C);
    bus(1'b0, BASE + 32'h10, 32'd0, 4'hF, 4);
    bus(1'b0, BASE + 32'h2000_0000, 32'd0, 4'hF, 2);

    // IRQ behaviour with a longer period.
    wr(8'h0C, 39); wr(8'h08, 1);
    idle(50);
    wait_phase(0, 5);
    wr(8'h04, 1);
    idle(4);
    check("irq_low_after_w1c", irq, 0);
    wait_phase(1, 0);
    wr(8'h04, 1);
    idle(3);
    check("irq_high_after_w1c_on_wrap", irq, 1);
    rd(8'h04);

    // Randomised traffic.
    for (int t = 0; t < 300; t++) begin
      automatic logic [31:0] adr;
      automatic logic [31:0] dat;
      automatic logic [3:0]  sel;
      adr = BASE + ($urandom_range(0, 10) * 4);
      if ($urandom_range(0, 15) == 0) adr = 32'h3000_0100 + ($urandom_range(0, 7) * 4);
      dat = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 15);
      if (adr[7:0] == 8'h00 && $urandom_range(0, 3) != 0) dat = dat | 32'h0000_0F01;
      sel = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      bus(1'($urandom), adr, dat, sel, $urandom_range(1, 3));
      idle($urandom_range(0, 12));
    end

    // Asynchronous reset in the middle of an acked transfer.
    wr(8'h00, 0); wr(8'h0C, 9); wr(8'h10, 32'hF_FFFF); wr(8'h08, 1); wr(8'h00, 32'h101);
    idle(15);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = BASE; wbs_sel_i = 4'hF;
    @(posedge clk); #2;
    check("pre_reset_ack", wbs_ack_o, 1);
    check("pre_reset_pwm0", pwm_o[0], 1);
    check("pre_reset_irq", irq, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_ack", wbs_ack_o, 0);
    check("async_reset_pwm", pwm_o, 0);
    check("async_reset_irq", irq, 0);
    wbs_cyc_i = 0; wbs_stb_i = 0;
    #12 rst_n = 1'b1;
    idle(2);
    rd(8'h0C); rd(8'h10); rd(8'h00);
    idle(3);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
